// File: rtl/spram_1r1w_adapter.sv
// Serializes independent read and write request streams onto one single-port
// RW0 SRAM macro. Writes park in a small FIFO; reads bypass parked writes and
// pick up their bytes through a registered forwarding snapshot, so the pair
// behaves as a coherent 1R1W memory.
module spram_1r1w_adapter #(
  parameter int AW         = 10,
  parameter int DW         = 32,
  parameter int MW         = DW / 8,
  parameter int WBUF_DEPTH = 2
) (
  input  logic          clock,
  input  logic          reset,
  // write request stream
  input  logic          w_valid,
  output logic          w_ready,
  input  logic [AW-1:0] w_addr,
  input  logic [DW-1:0] w_data,
  input  logic [MW-1:0] w_mask,
  // read request stream
  input  logic          r_valid,
  output logic          r_ready,
  input  logic [AW-1:0] r_addr,
  // read response
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  // macro port
  output logic [AW-1:0] RW0_addr,
  output logic          RW0_en,
  output logic          RW0_wmode,
  output logic [MW-1:0] RW0_wmask,
  output logic [DW-1:0] RW0_wdata,
  input  logic [DW-1:0] RW0_rdata,
  // status
  output logic          idle
);

  localparam int PW = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
  localparam int CW = $clog2(WBUF_DEPTH + 1);

  // Write buffer storage and bookkeeping
  logic [AW-1:0] buf_addr_q [WBUF_DEPTH];
  logic [DW-1:0] buf_data_q [WBUF_DEPTH];
  logic [MW-1:0] buf_mask_q [WBUF_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Read response pipeline: pending flag plus forwarding snapshot
  logic          rd_pend_q;
  logic [MW-1:0] fwd_mask_q, fwd_mask_d;
  logic [DW-1:0] fwd_data_q, fwd_data_d;
  logic [DW-1:0] rd_merge;

  logic buf_empty, buf_full;
  logic drain, read_fire, enq;

  assign buf_empty = (count_q == '0);
  assign buf_full  = (count_q == CW'(WBUF_DEPTH));

  // Draining only preempts a read when the buffer is full; otherwise reads win.
  assign drain     = !reset && !buf_empty && (buf_full || !r_valid);
  assign r_ready   = !reset && !buf_full;
  assign read_fire = r_valid && r_ready;
  assign w_ready   = !reset && !buf_full;
  // Zero-mask writes complete the handshake but never occupy the buffer.
  assign enq       = w_valid && w_ready && (w_mask != '0);

  // Macro port driven combinationally from the FIFO head or the read request
  always_comb begin
    RW0_en    = drain || read_fire;
    RW0_wmode = drain;
    RW0_addr  = drain ? buf_addr_q[rd_ptr_q] : r_addr;
    RW0_wmask = drain ? buf_mask_q[rd_ptr_q] : '0;
    RW0_wdata = buf_data_q[rd_ptr_q];
  end

  // Pointer and occupancy next state; pointers wrap naturally at the power of two
  always_comb begin
    wr_ptr_d = enq   ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = drain ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (enq && !drain) begin
      count_d = count_q + CW'(1);
    end else if (!enq && drain) begin
      count_d = count_q - CW'(1);
    end
  end

  // Forwarding snapshot: walk entries oldest to youngest so younger bytes override.
  // A write arriving this cycle is not yet stored, so a same-cycle read misses it.
  always_comb begin
    logic [PW-1:0] idx;
    fwd_mask_d = '0;
    fwd_data_d = '0;
    idx        = '0;
    for (int k = 0; k < WBUF_DEPTH; k++) begin
      idx = rd_ptr_q + PW'(k);
      if ((CW'(k) < count_q) && (buf_addr_q[idx] == r_addr)) begin
        for (int b = 0; b < MW; b++) begin
          if (buf_mask_q[idx][b]) begin
            fwd_mask_d[b]         = 1'b1;
            fwd_data_d[8*b +: 8]  = buf_data_q[idx][8*b +: 8];
          end
        end
      end
    end
  end

  // Buffer payload capture; contents need no reset since count gates validity
  always_ff @(posedge clock) begin
    if (enq) begin
      buf_addr_q[wr_ptr_q] <= w_addr;
      buf_data_q[wr_ptr_q] <= w_data;
      buf_mask_q[wr_ptr_q] <= w_mask;
    end
  end

  // Buffer pointers and occupancy, cleared by reset (buffered writes dropped)
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Read response tracking: register the accept and its forwarding snapshot
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_pend_q  <= 1'b0;
      fwd_mask_q <= '0;
      fwd_data_q <= '0;
    end else begin
      rd_pend_q <= read_fire;
      if (read_fire) begin
        fwd_mask_q <= fwd_mask_d;
        fwd_data_q <= fwd_data_d;
      end
    end
  end

  // Per-byte merge of forwarded data over macro read data
  for (genvar gi = 0; gi < MW; gi++) begin : g_merge
    assign rd_merge[8*gi +: 8] = fwd_mask_q[gi] ? fwd_data_q[8*gi +: 8]
                                                : RW0_rdata[8*gi +: 8];
  end

  assign rd_valid = rd_pend_q;
  assign rd_data  = rd_pend_q ? rd_merge : '0;
  assign idle     = buf_empty && !rd_pend_q;

endmodule

// File: tb/tb_spram_1r1w_adapter.sv
// Directed bench for spram_1r1w_adapter with a behavioural single-port macro.
module tb_spram_1r1w_adapter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        w_valid = 1'b0;
  logic        w_ready;
  logic [9:0]  w_addr = '0;
  logic [31:0] w_data = '0;
  logic [3:0]  w_mask = '0;
  logic        r_valid = 1'b0;
  logic        r_ready;
  logic [9:0]  r_addr = '0;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic [9:0]  RW0_addr;
  logic        RW0_en;
  logic        RW0_wmode;
  logic [3:0]  RW0_wmask;
  logic [31:0] RW0_wdata;
  logic [31:0] RW0_rdata;
  logic        idle;

  int checks = 0;
  int errors = 0;

  // macro model and activity monitor
  logic [31:0] mem [1024];
  logic [31:0] rdata_q;
  int en_ops = 0, wr_ops = 0, rd_acc = 0, rd_seen = 0;
  logic [9:0]  wlog_a [$];
  logic [31:0] wlog_d [$];

  assign RW0_rdata = rdata_q;

  always #5 clock = ~clock;

  spram_1r1w_adapter #(.AW(10), .DW(32), .MW(4), .WBUF_DEPTH(2)) dut (
    .clock(clock), .reset(reset),
    .w_valid(w_valid), .w_ready(w_ready), .w_addr(w_addr), .w_data(w_data), .w_mask(w_mask),
    .r_valid(r_valid), .r_ready(r_ready), .r_addr(r_addr),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .RW0_addr(RW0_addr), .RW0_en(RW0_en), .RW0_wmode(RW0_wmode),
    .RW0_wmask(RW0_wmask), .RW0_wdata(RW0_wdata), .RW0_rdata(RW0_rdata),
    .idle(idle)
  );

  always @(posedge clock) begin
    if (RW0_en) begin
      en_ops <= en_ops + 1;
      if (RW0_wmode) begin
        wr_ops <= wr_ops + 1;
        wlog_a.push_back(RW0_addr);
        wlog_d.push_back(RW0_wdata);
        for (int b = 0; b < 4; b++)
          if (RW0_wmask[b]) mem[RW0_addr][8*b +: 8] <= RW0_wdata[8*b +: 8];
      end else begin
        rdata_q <= mem[RW0_addr];
      end
    end
    if (r_valid && r_ready) rd_acc <= rd_acc + 1;
    if (rd_valid) rd_seen <= rd_seen + 1;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_w(input logic [9:0] a, input logic [31:0] d, input logic [3:0] m);
    w_valid = 1'b1; w_addr = a; w_data = d; w_mask = m;
  endtask

  task automatic do_write(input logic [9:0] a, input logic [31:0] d, input logic [3:0] m);
    drive_w(a, d, m);
    tick();
    w_valid = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (idle) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; r_valid = 1'b1; r_addr = 10'h001; drive_w(10'h002, 32'h1, 4'hF);
    tick(); tick();
    checks++;
    if (RW0_en !== 1'b0 || w_ready !== 1'b0 || r_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: en=%b w_ready=%b r_ready=%b required 0/0/0", RW0_en, w_ready, r_ready);
    end
    r_valid = 1'b0; w_valid = 1'b0; reset = 1'b0;
    #1;
    checks++;
    if (idle !== 1'b1 || rd_valid !== 1'b0 || rd_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: idle=%b rd_valid=%b rd_data=%h required 1/0/00000000", idle, rd_valid, rd_data);
    end
    $display("test_reset done");
  endtask

  task automatic test_plain_write_read();
    int w0;
    bit ok;
    w0 = wr_ops;
    do_write(10'h005, 32'hDEADBEEF, 4'hF);
    wait_idle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL plain_idle_timeout: idle=%b required 1", idle); end
    checks++;
    if (wr_ops - w0 !== 1 || wlog_a[wlog_a.size()-1] !== 10'h005) begin
      errors++;
      $display("FAIL plain_wr_ops: count=%0d required 1", wr_ops - w0);
    end
    r_valid = 1'b1; r_addr = 10'h005;
    #1;
    checks++;
    if (r_ready !== 1'b1) begin errors++; $display("FAIL plain_r_ready: got %b required 1", r_ready); end
    tick();
    r_valid = 1'b0;
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL plain_read: rd_valid=%b rd_data=%h required 1/deadbeef", rd_valid, rd_data);
    end
    tick();
    checks++;
    if (rd_valid !== 1'b0) begin errors++; $display("FAIL plain_pulse: rd_valid=%b required 0", rd_valid); end
    $display("test_plain_write_read done");
  endtask

  task automatic test_forward_merge();
    int w0;
    bit ok;
    do_write(10'h010, 32'h11223344, 4'hF);
    wait_idle(ok);
    w0 = wr_ops;
    do_write(10'h010, 32'h0000AAAA, 4'h3);
    r_valid = 1'b1; r_addr = 10'h010;
    #1;
    checks++;
    if (r_ready !== 1'b1 || RW0_wmode !== 1'b0) begin
      errors++;
      $display("FAIL fwd_read_wins: r_ready=%b wmode=%b required 1/0", r_ready, RW0_wmode);
    end
    tick();
    r_valid = 1'b0;
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 32'h1122AAAA || wr_ops !== w0) begin
      errors++;
      $display("FAIL fwd_merge: rd_valid=%b rd_data=%h wr_ops_delta=%0d required 1/1122aaaa/0",
               rd_valid, rd_data, wr_ops - w0);
    end
    wait_idle(ok);
    checks++;
    if (!ok || wr_ops - w0 !== 1 || mem[10'h010] !== 32'h1122AAAA) begin
      errors++;
      $display("FAIL fwd_drain: idle=%b delta=%0d mem=%h required 1/1/1122aaaa", idle, wr_ops - w0, mem[10'h010]);
    end
    $display("test_forward_merge done");
  endtask

  task automatic test_youngest_wins();
    bit ok;
    do_write(10'h020, 32'h00000000, 4'hF);
    wait_idle(ok);
    r_valid = 1'b1; r_addr = 10'h020;
    drive_w(10'h020, 32'h01020304, 4'hF);
    tick();
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 32'h00000000) begin
      errors++;
      $display("FAIL yw_first_read: rd_valid=%b rd_data=%h required 1/00000000", rd_valid, rd_data);
    end
    drive_w(10'h020, 32'h000000FF, 4'h1);
    tick();
    w_valid = 1'b0;
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 32'h01020304) begin
      errors++;
      $display("FAIL yw_second_read: rd_valid=%b rd_data=%h required 1/01020304", rd_valid, rd_data);
    end
    #1;
    checks++;
    if (r_ready !== 1'b0 || RW0_wmode !== 1'b1 || RW0_addr !== 10'h020 || RW0_wdata !== 32'h01020304) begin
      errors++;
      $display("FAIL yw_full_drain: r_ready=%b wmode=%b addr=%h wdata=%h required 0/1/020/01020304",
               r_ready, RW0_wmode, RW0_addr, RW0_wdata);
    end
    tick();
    checks++;
    if (rd_valid !== 1'b0) begin errors++; $display("FAIL yw_stall: rd_valid=%b required 0", rd_valid); end
    tick();
    r_valid = 1'b0;
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 32'h010203FF) begin
      errors++;
      $display("FAIL yw_merge: rd_valid=%b rd_data=%h required 1/010203ff", rd_valid, rd_data);
    end
    wait_idle(ok);
    $display("test_youngest_wins done");
  endtask

  task automatic test_same_cycle();
    bit ok;
    do_write(10'h030, 32'hCAFEF00D, 4'hF);
    wait_idle(ok);
    drive_w(10'h030, 32'h00000000, 4'hF);
    r_valid = 1'b1; r_addr = 10'h030;
    tick();
    w_valid = 1'b0;
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL same_cycle_old: rd_valid=%b rd_data=%h required 1/cafef00d", rd_valid, rd_data);
    end
    tick();
    r_valid = 1'b0;
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 32'h00000000) begin
      errors++;
      $display("FAIL same_cycle_new: rd_valid=%b rd_data=%h required 1/00000000", rd_valid, rd_data);
    end
    wait_idle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL same_cycle_idle: idle=%b required 1", idle); end
    $display("test_same_cycle done");
  endtask

  task automatic test_read_pressure();
    int w0, a0, s0, q0;
    bit ok;
    w0 = wr_ops; a0 = rd_acc; s0 = rd_seen; q0 = wlog_a.size();
    r_valid = 1'b1; r_addr = 10'h3F0;
    drive_w(10'h100, 32'h11111111, 4'hF);
    #1;
    checks++;
    if (w_ready !== 1'b1) begin errors++; $display("FAIL press_w1_ready: got %b required 1", w_ready); end
    tick();
    drive_w(10'h101, 32'h22222222, 4'hF);
    tick();
    drive_w(10'h102, 32'h33333333, 4'hF);
    #1;
    checks++;
    if (w_ready !== 1'b0 || r_ready !== 1'b0) begin
      errors++;
      $display("FAIL press_full: w_ready=%b r_ready=%b required 0/0", w_ready, r_ready);
    end
    tick();
    #1;
    checks++;
    if (w_ready !== 1'b1 || r_ready !== 1'b1) begin
      errors++;
      $display("FAIL press_recover: w_ready=%b r_ready=%b required 1/1", w_ready, r_ready);
    end
    tick();
    w_valid = 1'b0;
    tick();
    r_valid = 1'b0;
    tick();
    wait_idle(ok);
    checks++;
    if (!ok || wr_ops - w0 !== 3) begin
      errors++;
      $display("FAIL press_writes: idle=%b writes=%0d required 1/3", idle, wr_ops - w0);
    end
    checks++;
    if (wlog_a.size() < q0 + 3 || wlog_a[q0] !== 10'h100 || wlog_a[q0+1] !== 10'h101 || wlog_a[q0+2] !== 10'h102
        || wlog_d[q0+2] !== 32'h33333333) begin
      errors++;
      $display("FAIL press_order: log size=%0d required in-order 100/101/102", wlog_a.size() - q0);
    end
    checks++;
    if (rd_acc - a0 !== 3 || rd_seen - s0 !== 3) begin
      errors++;
      $display("FAIL press_reads: accepted=%0d responses=%0d required 3/3", rd_acc - a0, rd_seen - s0);
    end
    $display("test_read_pressure done");
  endtask

  task automatic test_reset_midop();
    int w0, e0;
    r_valid = 1'b1; r_addr = 10'h3F0;
    drive_w(10'h200, 32'hAAAA0000, 4'hF);
    tick();
    drive_w(10'h201, 32'hBBBB0000, 4'hF);
    tick();
    w_valid = 1'b0; r_valid = 1'b0;
    checks++;
    if (rd_valid !== 1'b1 || idle !== 1'b0) begin
      errors++;
      $display("FAIL midop_setup: rd_valid=%b idle=%b required 1/0", rd_valid, idle);
    end
    w0 = wr_ops; e0 = en_ops;
    reset = 1'b1;
    #1;
    checks++;
    if (RW0_en !== 1'b0) begin errors++; $display("FAIL midop_en_in_reset: got %b required 0", RW0_en); end
    tick();
    reset = 1'b0;
    checks++;
    if (rd_valid !== 1'b0 || idle !== 1'b1) begin
      errors++;
      $display("FAIL midop_after_reset: rd_valid=%b idle=%b required 0/1", rd_valid, idle);
    end
    tick(); tick(); tick();
    checks++;
    if (wr_ops !== w0) begin errors++; $display("FAIL midop_lost_writes: writes=%0d required 0", wr_ops - w0); end
    drive_w(10'h300, 32'hFFFFFFFF, 4'h0);
    #1;
    checks++;
    if (w_ready !== 1'b1) begin errors++; $display("FAIL zero_mask_ready: got %b required 1", w_ready); end
    tick();
    w_valid = 1'b0;
    tick(); tick();
    checks++;
    if (en_ops !== e0 || idle !== 1'b1) begin
      errors++;
      $display("FAIL zero_mask_dropped: ops=%0d idle=%b required 0/1", en_ops - e0, idle);
    end
    $display("test_reset_midop done");
  endtask

  initial begin
    test_reset();
    test_plain_write_read();
    test_forward_merge();
    test_youngest_wins();
    test_same_cycle();
    test_read_pressure();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
